ex_pipe_ctrl: RTL and testbench
===============================

Name: ex_pipe_ctrl

Overview:
- Pipeline sequencing controller for the EX stage of the RV32I core.
- Detects load-use hazards and taken branches/jumps in EX, and holds the pipeline for multi-cycle EX operations and memory back-pressure.
- Generates the stall, flush and redirect strobes for the PC, IF/ID, ID/EX and EX/MEM registers.
- Sits beside the EX stage. Forwarding from MEM/WB stays in the EX datapath; this block only handles hazards forwarding cannot cover.

Parameters:
MC_MAX_CYCLES, 34, maximum cycles a multi-cycle EX op may hold the pipeline before timeout
CNT_W, 32, width of performance counters (used only with optional feature)

Ports:
clk  input  1  core clock
rst  input  1  reset; synchronous, active-high
id_rs1  input  5  ID-stage source register 1
id_rs2  input  5  ID-stage source register 2
id_uses_rs1  input  1  ID instruction reads rs1
id_uses_rs2  input  1  ID instruction reads rs2
ex_dest  input  5  EX-stage destination register
ex_write_enable  input  1  EX instruction writes a register
ex_is_load  input  1  EX instruction is a load
branch_taken  input  1  EX branch resolved taken
is_jal  input  1  EX instruction is JAL
is_jalr  input  1  EX instruction is JALR
mc_start  input  1  EX holds a multi-cycle op (1-cycle pulse on entry)
mc_done  input  1  multi-cycle unit result valid
mem_busy  input  1  data memory not ready; freeze whole pipeline
stall_pc  output  1  hold PC
stall_if_id  output  1  hold IF/ID register
stall_id_ex  output  1  hold ID/EX register
flush_if_id  output  1  bubble IF/ID
flush_id_ex  output  1  bubble ID/EX
flush_ex_mem  output  1  bubble EX/MEM
redirect  output  1  load PC from EX target this cycle
redirect_sel  output  2  00 branch, 01 jal, 10 jalr
mc_timeout  output  1  sticky error, multi-cycle op exceeded MC_MAX_CYCLES
state_o  output  2  current state (debug)
stall_cycles  output  CNT_W  cycles with stall_pc high (optional feature)
flush_events  output  CNT_W  redirect count (optional feature)

Behaviour:
- States: RUN=0, FLUSH=1, MC_WAIT=2. The state register and wait counter are registered. Strobe outputs are combinational from state and inputs, so hazard response is in the same cycle.
- Reset (rst high at posedge):
  - state=RUN, wait_cnt=0, mc_timeout=0, counters=0.
  - While rst is high, all strobe outputs are 0 and redirect_sel=00.
  - Reset mid-MC_WAIT or mid-FLUSH aborts to RUN with no residual strobes.
- mem_busy=1 has the highest priority:
  - stall_pc, stall_if_id and stall_id_ex = 1.
  - All flush and redirect strobes = 0.
  - State and wait_cnt are frozen.
- RUN, redirect case:
  - Condition: redirect_req = branch_taken | is_jal | is_jalr.
  - Response: redirect=1, flush_if_id=1, flush_id_ex=1; next state FLUSH.
  - redirect_sel priority is jalr > jal > branch.
- RUN, load-use case (only when no redirect_req):
  - Condition: ex_is_load & ex_write_enable & ex_dest!=0 & ((id_uses_rs1 & id_rs1==ex_dest) | (id_uses_rs2 & id_rs2==ex_dest)).
  - Response: stall_pc=1, stall_if_id=1, flush_id_ex=1 (exactly one bubble); state stays RUN.
  - The bubble clears ex_is_load next cycle, releasing the stall.
- RUN, multi-cycle case:
  - mc_start with no redirect_req: stall_pc, stall_if_id and stall_id_ex = 1, flush_ex_mem=1, wait_cnt=0.
  - If mc_done is also high that cycle, no stall and state stays RUN. Otherwise next state MC_WAIT.
- FLUSH lasts exactly 1 cycle:
  - branch_taken, is_jal and is_jalr are ignored (EX holds a bubble), so redirect is never repeated.
  - Load-use and mc_start are evaluated as in RUN.
  - Next state RUN.
- MC_WAIT:
  - Stall pc/if_id/id_ex and flush_ex_mem every cycle; wait_cnt increments.
  - On mc_done: strobes deassert that same cycle; next state RUN.
  - If wait_cnt reaches MC_MAX_CYCLES-1 without mc_done: set mc_timeout (sticky until rst) and return to RUN.
- Illegal input combinations, flagged by simulation assertion, with defined resolution:
  - ex_is_load with mc_start: mc_start wins.
  - mc_start with redirect_req: redirect wins, mc_start dropped.
- wait_cnt width is $clog2(MC_MAX_CYCLES+1) and saturates, never wraps.

Optional Feature:
- Macro: EX_PIPE_CTRL_PERF_EN.
- When defined: stall_cycles increments on each cycle stall_pc=1, and flush_events increments on each redirect=1. Both wrap modulo 2^CNT_W and reset to 0.
- When undefined: both ports remain present and are tied to 0; no counter flops are generated.

Decomposition:
- Shared package ex_ctrl_pkg contains:
  - the state enum (RUN, FLUSH, MC_WAIT);
  - redirect_sel codes (SEL_BR, SEL_JAL, SEL_JALR);
  - the register-zero constant.
- One sub-module, ex_hazard_detect: purely combinational load-use comparator (id/ex register compare → load_use). It is instantiated once and reusable for a future second issue slot.

Test Plan:
- Load-use: ex_is_load=1, ex_write_enable=1, ex_dest=5, id_rs1=5, id_uses_rs1=1 → stall_pc=stall_if_id=flush_id_ex=1 for exactly 1 cycle; same with ex_dest=0 → no stall.
- Taken BEQ: branch_taken=1 → redirect=1, redirect_sel=00, flush_if_id=flush_id_ex=1, state_o=1. Holding branch_taken=1 for 2 cycles → only one redirect pulse.
- JALR and JAL both high → redirect_sel=10.
- Multi-cycle op: mc_start pulse, mc_done after 5 cycles → stall_pc high 6 cycles with flush_ex_mem high throughout, then state_o=0. mc_start with mc_done same cycle → no stall.
- Timeout: mc_start, mc_done never asserted, MC_MAX_CYCLES=34 → mc_timeout=1 after 34 stall cycles; remains 1 until rst.
- mem_busy=1 during MC_WAIT for 3 cycles → wait_cnt frozen, flush_ex_mem=0; rst asserted mid-MC_WAIT → next cycle all strobes 0, state_o=0.

Source files
------------

// File: rtl/ex_ctrl_pkg.sv
// Shared types and constants for the EX-stage pipeline controller.
package ex_ctrl_pkg;

    localparam int unsigned REG_W = 5;
    localparam int unsigned SEL_W = 2;

    localparam logic [REG_W-1:0] REG_ZERO = REG_W'(0);

    // Controller states; the encoding is visible on state_o
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        FLUSH   = 2'd1,
        MC_WAIT = 2'd2
    } state_e;

    // PC target select presented with redirect
    localparam logic [SEL_W-1:0] SEL_BR   = 2'b00;
    localparam logic [SEL_W-1:0] SEL_JAL  = 2'b01;
    localparam logic [SEL_W-1:0] SEL_JALR = 2'b10;

endpackage

// File: rtl/ex_pipe_ctrl_if.sv
// ID/EX hazard inputs and pipeline strobes between the EX stage and its controller.
interface ex_pipe_ctrl_if;
    import ex_ctrl_pkg::*;

    logic [REG_W-1:0] id_rs1;
    logic [REG_W-1:0] id_rs2;
    logic             id_uses_rs1;
    logic             id_uses_rs2;
    logic [REG_W-1:0] ex_dest;
    logic             ex_write_enable;
    logic             ex_is_load;
    logic             branch_taken;
    logic             is_jal;
    logic             is_jalr;
    logic             mc_start;
    logic             mc_done;
    logic             mem_busy;

    logic             stall_pc;
    logic             stall_if_id;
    logic             stall_id_ex;
    logic             flush_if_id;
    logic             flush_id_ex;
    logic             flush_ex_mem;
    logic             redirect;
    logic [SEL_W-1:0] redirect_sel;

    // Pipeline side: supplies hazard information, consumes strobes
    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_dest, ex_write_enable,
               ex_is_load, branch_taken, is_jal, is_jalr, mc_start, mc_done, mem_busy,
        input  stall_pc, stall_if_id, stall_id_ex, flush_if_id, flush_id_ex,
               flush_ex_mem, redirect, redirect_sel
    );

    // Controller side
    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_dest, ex_write_enable,
               ex_is_load, branch_taken, is_jal, is_jalr, mc_start, mc_done, mem_busy,
        output stall_pc, stall_if_id, stall_id_ex, flush_if_id, flush_id_ex,
               flush_ex_mem, redirect, redirect_sel
    );

endinterface

// File: rtl/ex_hazard_detect.sv
// Load-use comparator: an ID operand depends on a load still in EX.
module ex_hazard_detect
    import ex_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [REG_W-1:0] ex_dest,
    input  logic             ex_write_enable,
    input  logic             ex_is_load,
    output logic             load_use_c
);

    logic rs1_hit_c;
    logic rs2_hit_c;

    // x0 never carries a dependency, so a load targeting it never stalls
    always_comb begin
        rs1_hit_c  = id_uses_rs1 && (id_rs1 == ex_dest);
        rs2_hit_c  = id_uses_rs2 && (id_rs2 == ex_dest);
        load_use_c = ex_is_load && ex_write_enable && (ex_dest != REG_ZERO)
                     && (rs1_hit_c || rs2_hit_c);
    end

endmodule

// File: rtl/ex_pipe_ctrl.sv
// EX-stage sequencing controller: stall/flush/redirect strobes for load-use,
// taken control transfers, multi-cycle EX ops and memory back-pressure.
// Optional build macro EX_PIPE_CTRL_PERF_EN adds stall/redirect counters.
module ex_pipe_ctrl
    import ex_ctrl_pkg::*;
#(
    parameter int unsigned MC_MAX_CYCLES = 34,
    parameter int unsigned CNT_W         = 32
) (
    input  logic              clk,
    input  logic              rst,
    ex_pipe_ctrl_if.slave     pif,
    output logic              mc_timeout,
    output logic [1:0]        state_o,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_events
);

    localparam int unsigned       WAIT_W    = $clog2(MC_MAX_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MC_MAX_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_SAT  = '1;

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mc_timeout_q, mc_timeout_d;
    logic              load_use_c;
    logic              redirect_req_c;

    ex_hazard_detect u_hazard (
        .id_rs1          (pif.id_rs1),
        .id_rs2          (pif.id_rs2),
        .id_uses_rs1     (pif.id_uses_rs1),
        .id_uses_rs2     (pif.id_uses_rs2),
        .ex_dest         (pif.ex_dest),
        .ex_write_enable (pif.ex_write_enable),
        .ex_is_load      (pif.ex_is_load),
        .load_use_c      (load_use_c)
    );

    assign redirect_req_c = pif.branch_taken | pif.is_jal | pif.is_jalr;

    // Next-state and same-cycle strobes; wait_cnt holds the index of the current
    // hold cycle, the mc_start cycle being hold 0
    always_comb begin
        state_d          = state_q;
        wait_cnt_d       = wait_cnt_q;
        mc_timeout_d     = mc_timeout_q;
        pif.stall_pc     = 1'b0;
        pif.stall_if_id  = 1'b0;
        pif.stall_id_ex  = 1'b0;
        pif.flush_if_id  = 1'b0;
        pif.flush_id_ex  = 1'b0;
        pif.flush_ex_mem = 1'b0;
        pif.redirect     = 1'b0;
        pif.redirect_sel = SEL_BR;
        if (rst) begin
            state_d = RUN;
        end else if (pif.mem_busy) begin
            pif.stall_pc    = 1'b1;
            pif.stall_if_id = 1'b1;
            pif.stall_id_ex = 1'b1;
        end else begin
            unique case (state_q)
                RUN, FLUSH: begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                    if ((state_q == RUN) && redirect_req_c) begin
                        pif.redirect    = 1'b1;
                        pif.flush_if_id = 1'b1;
                        pif.flush_id_ex = 1'b1;
                        state_d         = FLUSH;
                        if (pif.is_jalr)     pif.redirect_sel = SEL_JALR;
                        else if (pif.is_jal) pif.redirect_sel = SEL_JAL;
                        else                 pif.redirect_sel = SEL_BR;
                    end else if (pif.mc_start) begin
                        if (!pif.mc_done) begin
                            pif.stall_pc     = 1'b1;
                            pif.stall_if_id  = 1'b1;
                            pif.stall_id_ex  = 1'b1;
                            pif.flush_ex_mem = 1'b1;
                            state_d          = MC_WAIT;
                            wait_cnt_d       = WAIT_W'(1);
                        end
                    end else if (load_use_c) begin
                        pif.stall_pc    = 1'b1;
                        pif.stall_if_id = 1'b1;
                        pif.flush_id_ex = 1'b1;
                    end
                end
                MC_WAIT: begin
                    if (pif.mc_done) begin
                        state_d    = RUN;
                        wait_cnt_d = '0;
                    end else begin
                        pif.stall_pc     = 1'b1;
                        pif.stall_if_id  = 1'b1;
                        pif.stall_id_ex  = 1'b1;
                        pif.flush_ex_mem = 1'b1;
                        if (wait_cnt_q >= WAIT_LAST) begin
                            mc_timeout_d = 1'b1;
                            state_d      = RUN;
                            wait_cnt_d   = '0;
                        end else if (wait_cnt_q != WAIT_SAT) begin
                            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                        end
                    end
                end
                default: begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end
            endcase
        end
    end

    // State, hold counter and sticky timeout flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RUN;
            wait_cnt_q   <= '0;
            mc_timeout_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            mc_timeout_q <= mc_timeout_d;
        end
    end

    assign mc_timeout = mc_timeout_q;
    assign state_o    = state_q;

`ifdef EX_PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] flush_events_q, flush_events_d;

    // Free-running wrap-around event counters
    always_comb begin
        stall_cycles_d = stall_cycles_q + CNT_W'(pif.stall_pc);
        flush_events_d = flush_events_q + CNT_W'(pif.redirect);
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= '0;
            flush_events_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_events_q <= flush_events_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_events = flush_events_q;
`else
    assign stall_cycles = '0;
    assign flush_events = '0;
`endif

    // mc_start must arrive on its own: not with a load, and not with a redirect in RUN
    property p_mc_no_load;
        @(posedge clk) disable iff (rst)
            (pif.mc_start && !pif.mem_busy && (state_q != MC_WAIT)) |-> !pif.ex_is_load;
    endproperty
    property p_mc_no_redirect;
        @(posedge clk) disable iff (rst)
            (pif.mc_start && !pif.mem_busy && (state_q == RUN)) |-> !redirect_req_c;
    endproperty
    a_mc_no_load:     assert property (p_mc_no_load)     else $error("mc_start with ex_is_load");
    a_mc_no_redirect: assert property (p_mc_no_redirect) else $error("mc_start with redirect request");

endmodule

// File: tb/tb_ex_pipe_ctrl.sv
// Self-checking bench for ex_pipe_ctrl: directed scenarios followed by
// constrained-random traffic, all checked against a cycle-level reference model.
module tb_ex_pipe_ctrl;

    localparam int unsigned MC_MAX = 34;
    localparam int unsigned CNT_W  = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             mc_timeout;
    logic [1:0]       state_o;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;

    ex_pipe_ctrl_if pif ();

    ex_pipe_ctrl #(.MC_MAX_CYCLES(MC_MAX), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .pif          (pif.slave),
        .mc_timeout   (mc_timeout),
        .state_o      (state_o),
        .stall_cycles (stall_cycles),
        .flush_events (flush_events)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: pending multi-cycle op, hold cycles spent, redirect just issued
    bit          m_mc, m_fl, m_to;
    int          m_held;
    int unsigned m_stalls, m_flushes;

    // Last observed values, for directed checks
    bit       o_spc, o_red, o_fem, o_to;
    bit [1:0] o_sel, o_st;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        pif.id_rs1 = '0; pif.id_rs2 = '0; pif.id_uses_rs1 = 1'b0; pif.id_uses_rs2 = 1'b0;
        pif.ex_dest = '0; pif.ex_write_enable = 1'b0; pif.ex_is_load = 1'b0;
        pif.branch_taken = 1'b0; pif.is_jal = 1'b0; pif.is_jalr = 1'b0;
        pif.mc_start = 1'b0; pif.mc_done = 1'b0; pif.mem_busy = 1'b0;
    endtask

    // One clock: compare all outputs against the model, then advance the model
    task automatic step();
        bit       spc, sif, sie, fif, fie, fem, red, hit, req;
        bit [1:0] sel, st;
        @(negedge clk);
        {spc, sif, sie, fif, fie, fem, red} = '0;
        sel = 2'd0;
        st  = m_mc ? 2'd2 : (m_fl ? 2'd1 : 2'd0);
        check_eq("state_o", state_o, st);
        check_eq("mc_timeout", mc_timeout, m_to);
`ifdef EX_PIPE_CTRL_PERF_EN
        check_eq("stall_cycles", stall_cycles, m_stalls);
        check_eq("flush_events", flush_events, m_flushes);
`else
        check_eq("stall_cycles", stall_cycles, 0);
        check_eq("flush_events", flush_events, 0);
`endif
        if (rst) begin
            m_mc = 0; m_fl = 0; m_to = 0; m_held = 0; m_stalls = 0; m_flushes = 0;
        end else if (pif.mem_busy) begin
            spc = 1; sif = 1; sie = 1;
        end else if (m_mc) begin
            if (pif.mc_done) begin
                m_mc = 0;
            end else begin
                spc = 1; sif = 1; sie = 1; fem = 1;
                m_held++;
                if (m_held == MC_MAX) begin
                    m_to = 1;
                    m_mc = 0;
                end
            end
        end else begin
            req  = !m_fl && (pif.branch_taken || pif.is_jal || pif.is_jalr);
            m_fl = 0;
            hit  = pif.ex_is_load && pif.ex_write_enable && (pif.ex_dest != 0) &&
                   ((pif.id_uses_rs1 && pif.id_rs1 == pif.ex_dest) ||
                    (pif.id_uses_rs2 && pif.id_rs2 == pif.ex_dest));
            if (req) begin
                red = 1; fif = 1; fie = 1; m_fl = 1;
                sel = pif.is_jalr ? 2'd2 : (pif.is_jal ? 2'd1 : 2'd0);
            end else if (pif.mc_start) begin
                if (!pif.mc_done) begin
                    spc = 1; sif = 1; sie = 1; fem = 1;
                    m_mc = 1; m_held = 1;
                end
            end else if (hit) begin
                spc = 1; sif = 1; fie = 1;
            end
        end
        if (!rst) begin
            m_stalls  += 32'(spc);
            m_flushes += 32'(red);
        end
        check_eq("stall_pc", pif.stall_pc, spc);
        check_eq("stall_if_id", pif.stall_if_id, sif);
        check_eq("stall_id_ex", pif.stall_id_ex, sie);
        check_eq("flush_if_id", pif.flush_if_id, fif);
        check_eq("flush_id_ex", pif.flush_id_ex, fie);
        check_eq("flush_ex_mem", pif.flush_ex_mem, fem);
        check_eq("redirect", pif.redirect, red);
        check_eq("redirect_sel", pif.redirect_sel, sel);
        o_spc = pif.stall_pc; o_red = pif.redirect; o_fem = pif.flush_ex_mem;
        o_sel = pif.redirect_sel; o_st = state_o; o_to = mc_timeout;
        @(posedge clk);
        #1;
    endtask

    // Legal random cycle; pct_done sets how quickly multi-cycle ops finish
    task automatic rand_inputs(input int pct_done);
        pif.id_rs1          = 5'($urandom_range(0, 3));
        pif.id_rs2          = 5'($urandom_range(0, 3));
        pif.id_uses_rs1     = 1'($urandom_range(0, 1));
        pif.id_uses_rs2     = 1'($urandom_range(0, 1));
        pif.ex_dest         = 5'($urandom_range(0, 3));
        pif.ex_write_enable = ($urandom_range(0, 99) < 80);
        pif.ex_is_load      = ($urandom_range(0, 99) < 35);
        pif.branch_taken    = ($urandom_range(0, 99) < 12);
        pif.is_jal          = ($urandom_range(0, 99) < 6);
        pif.is_jalr         = ($urandom_range(0, 99) < 6);
        pif.mc_done         = ($urandom_range(0, 99) < pct_done);
        pif.mem_busy        = ($urandom_range(0, 99) < 10);
        pif.mc_start        = !m_mc && ($urandom_range(0, 99) < 12);
        if (pif.mc_start) begin
            pif.ex_is_load = 1'b0; pif.branch_taken = 1'b0; pif.is_jal = 1'b0; pif.is_jalr = 1'b0;
        end
        rst = ($urandom_range(0, 999) < 5);
    endtask

    initial begin
        int cnt_stall, cnt_red;
        idle();
        rst = 1'b1;
        @(posedge clk); #1;
        m_mc = 0; m_fl = 0; m_to = 0; m_held = 0; m_stalls = 0; m_flushes = 0;
        step();
        check_eq("rst_state", o_st, 0);
        rst = 1'b0;

        // Load-use: exactly one bubble, then none for x0
        pif.ex_is_load = 1; pif.ex_write_enable = 1; pif.ex_dest = 5'd5;
        pif.id_rs1 = 5'd5; pif.id_uses_rs1 = 1;
        step();
        check_eq("lu_stall", o_spc, 1);
        pif.ex_is_load = 0;
        step();
        check_eq("lu_release", o_spc, 0);
        pif.ex_is_load = 1; pif.ex_dest = 5'd0; pif.id_rs1 = 5'd0;
        step();
        check_eq("lu_x0", o_spc, 0);
        idle();

        // Taken branch held two cycles: single redirect pulse
        pif.branch_taken = 1;
        cnt_red = 0;
        step(); cnt_red += int'(o_red);
        check_eq("br_sel", o_sel, 0);
        step(); cnt_red += int'(o_red);
        check_eq("br_flush_state", o_st, 1);
        check_eq("br_pulses", cnt_red, 1);
        idle();
        step();

        // JAL and JALR together select JALR
        pif.is_jal = 1; pif.is_jalr = 1;
        step();
        check_eq("jalr_sel", o_sel, 2);
        idle();
        step();

        // Multi-cycle op finishing six cycles after entry
        cnt_stall = 0;
        pif.mc_start = 1;
        step(); cnt_stall += int'(o_spc);
        pif.mc_start = 0;
        for (int i = 0; i < 5; i++) begin
            step(); cnt_stall += int'(o_spc);
        end
        pif.mc_done = 1;
        step(); cnt_stall += int'(o_spc);
        pif.mc_done = 0;
        check_eq("mc_stall_cycles", cnt_stall, 6);
        step();
        check_eq("mc_back_to_run", o_st, 0);
        pif.mc_start = 1; pif.mc_done = 1;
        step();
        check_eq("mc_same_cycle", o_spc, 0);
        idle();
        step();

        // Timeout: no mc_done ever
        cnt_stall = 0;
        pif.mc_start = 1;
        step(); cnt_stall += int'(o_spc);
        pif.mc_start = 0;
        for (int i = 0; i < 40; i++) begin
            step(); cnt_stall += int'(o_spc);
        end
        check_eq("to_stall_cycles", cnt_stall, MC_MAX);
        check_eq("to_sticky", o_to, 1);
        rst = 1;
        step();
        rst = 0;
        step();
        check_eq("to_cleared", o_to, 0);

        // mem_busy inside MC_WAIT, then reset mid-wait
        pif.mc_start = 1;
        step();
        pif.mc_start = 0;
        step(); step();
        pif.mem_busy = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("busy_no_fem", o_fem, 0);
        end
        pif.mem_busy = 0;
        step();
        rst = 1;
        step();
        rst = 0;
        step();
        check_eq("rst_mid_wait", o_st, 0);

        // Random traffic: fast, slow and stalled completion regimes
        for (int ph = 0; ph < 3; ph++) begin
            for (int i = 0; i < 1500; i++) begin
                rand_inputs(ph == 0 ? 30 : (ph == 1 ? 8 : 1));
                step();
            end
        end
        idle();
        rst = 0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
